// File: rtl/ftps_stroke_tracker.sv
// Fingertip stroke tracker: smooths fingertip points, rejects jumps,
// tracks pen state and queues stroke points / end markers in a FIFO.
module ftps_stroke_tracker #(
  parameter int ARM_FRAMES = 4,
  parameter int END_FRAMES = 8,
  parameter int MAX_JUMP   = 40,
  parameter int FIFO_DEPTH = 64
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic [8:0] x_in,
  input  logic [7:0] y_in,
  input  logic       pt_valid,
  output logic [8:0] out_x,
  output logic [7:0] out_y,
  output logic       out_end,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       stroke_active,
  output logic       overflow,
  output logic [6:0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] ARM_N = 8'(ARM_FRAMES);
  localparam logic [7:0] END_N = 8'(END_FRAMES);
  localparam logic [9:0] JMAX  = 10'(MAX_JUMP);
  localparam logic [6:0] FULL  = 7'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, DRAW, LOST} state_t;

  state_t     state_q, state_d;
  logic [7:0] arm_q, arm_d;
  logic [7:0] lost_q, lost_d;
  logic [8:0] hx_q [4];
  logic [8:0] hx_d [4];
  logic [7:0] hy_q [4];
  logic [7:0] hy_d [4];
  logic       pt_q, pt_d;
  logic       pe_q, pe_d;
  logic       act_q, act_d;

  logic       rq_pt_q, rq_pt_d;
  logic       rq_end_q, rq_end_d;
  logic [8:0] rx_q, rx_d;
  logic [7:0] ry_q, ry_d;

  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          wr;
  logic [17:0]   wdata;

  logic              present;
  logic              accept;
  logic signed [9:0] dx, dy;
  logic [9:0]        adx, ady, jump;
  logic              do_push, do_end;
  logic [10:0]       sx;
  logic [9:0]        sy;
  logic              pop, room;
  logic [17:0]       head;

  assign present = pt_valid && !(x_in == 9'd0 && y_in == 8'd0);
  assign dx   = $signed({1'b0, x_in}) - $signed({1'b0, hx_q[0]});
  assign dy   = $signed({2'b0, y_in}) - $signed({2'b0, hy_q[0]});
  assign adx  = dx[9] ? 10'(-dx) : 10'(dx);
  assign ady  = dy[9] ? 10'(-dy) : 10'(dy);
  assign jump = adx + ady;
  assign accept = present && !(state_q == DRAW && jump > JMAX);

  // Pen-state FSM and raw point history, advanced on each frame pulse
  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    lost_d  = lost_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    pt_d    = 1'b0;
    pe_d    = 1'b0;
    act_d   = (state_q == DRAW) || (state_q == LOST);
    do_push = 1'b0;
    do_end  = 1'b0;
    if (pt_valid) begin
      unique case (state_q)
        IDLE: begin
          if (present) begin
            state_d = ARM;
            arm_d   = 8'd1;
            do_push = 1'b1;
          end
        end
        ARM: begin
          if (present) begin
            do_push = 1'b1;
            arm_d   = arm_q + 8'd1;
            if (arm_q + 8'd1 == ARM_N) begin
              state_d = DRAW;
              arm_d   = 8'd0;
              lost_d  = 8'd0;
              pt_d    = 1'b1;
            end
          end else begin
            state_d = IDLE;
            arm_d   = 8'd0;
          end
        end
        DRAW: begin
          if (accept) begin
            do_push = 1'b1;
            pt_d    = 1'b1;
            lost_d  = 8'd0;
          end else if (END_N == 8'd1) begin
            do_end = 1'b1;
          end else begin
            state_d = LOST;
            lost_d  = 8'd1;
          end
        end
        LOST: begin
          if (accept) begin
            do_push = 1'b1;
            pt_d    = 1'b1;
            state_d = DRAW;
            lost_d  = 8'd0;
          end else if (lost_q + 8'd1 == END_N) begin
            do_end = 1'b1;
          end else begin
            lost_d = lost_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (do_push) begin
      for (int i = 3; i > 0; i--) begin
        hx_d[i] = hx_q[i-1];
        hy_d[i] = hy_q[i-1];
      end
      hx_d[0] = x_in;
      hy_d[0] = y_in;
    end
    if (do_end) begin
      for (int i = 0; i < 4; i++) begin
        hx_d[i] = 9'd0;
        hy_d[i] = 8'd0;
      end
      state_d = IDLE;
      lost_d  = 8'd0;
      arm_d   = 8'd0;
      pe_d    = 1'b1;
    end
  end

  // Averaging stage: truncated 4-point mean of the updated history
  always_comb begin
    sx = 11'(hx_q[0]) + 11'(hx_q[1]) + 11'(hx_q[2]) + 11'(hx_q[3]);
    sy = 10'(hy_q[0]) + 10'(hy_q[1]) + 10'(hy_q[2]) + 10'(hy_q[3]);
    rq_pt_d  = pt_q;
    rq_end_d = pe_q;
    rx_d = pe_q ? 9'd0 : 9'(sx >> 2);
    ry_d = pe_q ? 8'd0 : 8'(sy >> 2);
  end

  // FIFO write arbitration; end markers wait in a pending slot when full
  always_comb begin
    pop    = out_valid && out_ready;
    room   = (cnt_q != FULL) || pop;
    wr     = 1'b0;
    wdata  = 18'd0;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (pend_q) begin
      if (room) begin
        wr     = 1'b1;
        wdata  = {1'b1, 17'd0};
        pend_d = rq_end_q;
      end
      if (rq_pt_q) ovf_d = 1'b1;
    end else if (rq_end_q) begin
      if (room) begin
        wr    = 1'b1;
        wdata = {1'b1, 17'd0};
      end else begin
        pend_d = 1'b1;
      end
    end else if (rq_pt_q) begin
      if (room) begin
        wr    = 1'b1;
        wdata = {1'b0, ry_q, rx_q};
      end else begin
        ovf_d = 1'b1;
      end
    end
    cnt_d = cnt_q + 7'(wr) - 7'(pop);
    wp_d  = wp_q + AW'(wr);
    rp_d  = rp_q + AW'(pop);
  end

  // All control and pipeline state
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q  <= IDLE;
      arm_q    <= 8'd0;
      lost_q   <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        hx_q[i] <= 9'd0;
        hy_q[i] <= 8'd0;
      end
      pt_q     <= 1'b0;
      pe_q     <= 1'b0;
      act_q    <= 1'b0;
      rq_pt_q  <= 1'b0;
      rq_end_q <= 1'b0;
      rx_q     <= 9'd0;
      ry_q     <= 8'd0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= 7'd0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      arm_q    <= arm_d;
      lost_q   <= lost_d;
      hx_q     <= hx_d;
      hy_q     <= hy_d;
      pt_q     <= pt_d;
      pe_q     <= pe_d;
      act_q    <= act_d;
      rq_pt_q  <= rq_pt_d;
      rq_end_q <= rq_end_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are masked at the outputs while empty
  always_ff @(posedge pclk) begin
    if (wr) mem_q[wp_q] <= wdata;
  end

  assign head          = mem_q[rp_q];
  assign out_valid     = cnt_q != 7'd0;
  assign out_x         = out_valid ? head[8:0] : 9'd0;
  assign out_y         = out_valid ? head[16:9] : 8'd0;
  assign out_end       = out_valid ? head[17] : 1'b0;
  assign fifo_count    = cnt_q;
  assign overflow      = ovf_q;
  assign stroke_active = act_q;

endmodule

// File: tb/tb_ftps_stroke_tracker.sv
// Directed bench for ftps_stroke_tracker with a scoreboard queue
// of expected FIFO entries checked as the consumer drains them.
module tb_ftps_stroke_tracker;

  logic       pclk = 1'b0;
  logic       reset;
  logic [8:0] x_in;
  logic [7:0] y_in;
  logic       pt_valid;
  logic [8:0] out_x;
  logic [7:0] out_y;
  logic       out_end;
  logic       out_valid;
  logic       out_ready;
  logic       stroke_active;
  logic       overflow;
  logic [6:0] fifo_count;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [17:0] sb [$];
  logic [8:0]  mx [4];
  logic [7:0]  my [4];

  ftps_stroke_tracker dut (
    .pclk(pclk), .reset(reset),
    .x_in(x_in), .y_in(y_in), .pt_valid(pt_valid),
    .out_x(out_x), .out_y(out_y), .out_end(out_end),
    .out_valid(out_valid), .out_ready(out_ready),
    .stroke_active(stroke_active), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks += 1;
    assert (obs === exp) passes += 1;
    else begin
      fails += 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic frame(input logic [8:0] x, input logic [7:0] y);
    x_in = x;
    y_in = y;
    pt_valid = 1'b1;
    tick(1);
    pt_valid = 1'b0;
    x_in = 9'd0;
    y_in = 8'd0;
    tick(4);
  endtask

  task automatic mpush(input logic [8:0] x, input logic [7:0] y);
    for (int i = 3; i > 0; i--) begin
      mx[i] = mx[i-1];
      my[i] = my[i-1];
    end
    mx[0] = x;
    my[0] = y;
  endtask

  task automatic mclear();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 9'd0;
      my[i] = 8'd0;
    end
  endtask

  task automatic expect_avg();
    int sx;
    int sy;
    sx = int'(mx[0]) + int'(mx[1]) + int'(mx[2]) + int'(mx[3]);
    sy = int'(my[0]) + int'(my[1]) + int'(my[2]) + int'(my[3]);
    sb.push_back({1'b0, 8'(sy / 4), 9'(sx / 4)});
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) tick(1);
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Consumer side: every accepted head must match the scoreboard
  always @(negedge pclk) begin
    if (!reset && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0)
        chk("sb_head", 32'({out_end, out_y, out_x}), 32'(sb.pop_front()));
    end
  end

  initial begin
    reset = 1'b1;
    pt_valid = 1'b0;
    x_in = 9'd0;
    y_in = 8'd0;
    out_ready = 1'b0;
    mclear();
    tick(3);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_active", 32'(stroke_active), 32'd0);
    chk("rst_x", 32'(out_x), 32'd0);
    chk("rst_end", 32'(out_end), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick(2);

    // short arm then absent: nothing queued
    for (int i = 0; i < 3; i++) begin
      mpush(9'd100, 8'd50);
      frame(9'd100, 8'd50);
    end
    frame(9'd0, 8'd0);
    tick(2);
    chk("t1_count", 32'(fifo_count), 32'd0);
    chk("t1_active", 32'(stroke_active), 32'd0);

    // full arm: first averaged point, with latency check
    mpush(9'd100, 8'd50); frame(9'd100, 8'd50);
    mpush(9'd104, 8'd50); frame(9'd104, 8'd50);
    mpush(9'd108, 8'd54); frame(9'd108, 8'd54);
    mpush(9'd112, 8'd54);
    expect_avg();
    x_in = 9'd112;
    y_in = 8'd54;
    pt_valid = 1'b1;
    tick(1);
    pt_valid = 1'b0;
    x_in = 9'd0;
    y_in = 8'd0;
    tick(1);
    chk("t2_lat2", 32'(out_valid), 32'd0);
    tick(1);
    chk("t2_lat3", 32'(out_valid), 32'd1);
    chk("t2_x", 32'(out_x), 32'd106);
    tick(2);
    chk("t2_active", 32'(stroke_active), 32'd1);
    drain();

    // jump rejected, then recovery from LOST
    frame(9'd200, 8'd54);
    chk("t3_nojump", 32'(fifo_count), 32'd0);
    chk("t3_active", 32'(stroke_active), 32'd1);
    mpush(9'd114, 8'd54);
    expect_avg();
    frame(9'd114, 8'd54);
    drain();

    // end of stroke after 8 absent frames
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) sb.push_back({1'b1, 17'd0});
      frame(9'd0, 8'd0);
    end
    mclear();
    chk("t4_count", 32'(fifo_count), 32'd1);
    chk("t4_active", 32'(stroke_active), 32'd0);
    chk("t4_end", 32'(out_end), 32'd1);
    out_ready = 1'b1;
    drain();

    // fill the FIFO, overflow, then a pending end marker
    out_ready = 1'b0;
    for (int i = 0; i < 68; i++) begin
      mpush(9'(10 + i), 8'd100);
      if (i >= 3 && i < 67) expect_avg();
      frame(9'(10 + i), 8'd100);
    end
    chk("t5_full", 32'(fifo_count), 32'd64);
    chk("t5_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) frame(9'd0, 8'd0);
    mclear();
    sb.push_back({1'b1, 17'd0});
    chk("t5_pend_full", 32'(fifo_count), 32'd64);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(3);
    chk("t5_pend_wr", 32'(fifo_count), 32'd64);
    out_ready = 1'b1;
    drain();
    chk("t5_ovf_sticky", 32'(overflow), 32'd1);

    // reset mid-stroke flushes everything, no end marker
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) frame(9'(200 + i), 8'd20);
    chk("t6_count", 32'(fifo_count), 32'd5);
    chk("t6_active", 32'(stroke_active), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_zero", 32'(fifo_count), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick(40);
    chk("t6_noend", 32'(fifo_count), 32'd0);
    chk("t6_idle", 32'(stroke_active), 32'd0);
    chk("t6_sb", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
